svt_objection_ctrl: RTL and testbench
=====================================

Name: svt_objection_ctrl

Overview:
- Synthesizable end-of-test controller on the DUT/harness side.
- Aggregates raise/drop objection pulses from NUM_SRC hardware agents into one objection count.
- Applies a drain time once the count reaches zero, and runs a watchdog timeout.
- Its done/timed_out outputs are what the testbench test-runner waits on before ending simulation.

Parameters:
- NUM_SRC, 4: number of objection source lanes.
- CNT_W, 8: width of the objection counter; saturates at 2^CNT_W-1.
- TIMEOUT_W, 32: width of the watchdog cycle counter and limit.
- DRAIN_CYCLES, 16: cycles the count must stay zero before done; legal range >=1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; arms or re-arms the controller.
- raise  in  NUM_SRC  per-lane pulse: add one objection.
- drop  in  NUM_SRC  per-lane pulse: remove one objection.
- timeout_limit  in  TIMEOUT_W  watchdog limit in cycles; 0 disables it; sampled every cycle.
- objection_count  out  CNT_W  registered current objection count.
- elapsed  out  TIMEOUT_W  cycles spent in ACTIVE/DRAIN since last start.
- busy  out  1  high in ACTIVE or DRAIN.
- done  out  1  sticky: drain completed with zero objections.
- timed_out  out  1  sticky: watchdog expired.
- err_underflow  out  1  sticky: drop received that would take the count below 0.
- err_overflow  out  1  sticky: raise received that would take the count above max.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs and internal counters 0.
- Count update, every cycle in every state:
  - net = popcount(raise) - popcount(drop); next count = clamp(count + net, 0, 2^CNT_W-1).
  - Computed at width CNT_W+$clog2(NUM_SRC)+2, signed.
  - A lane with raise and drop together contributes 0.
  - Clamp at 0 sets err_underflow; clamp at max sets err_overflow. Both errors clear only on start or reset.
- States: IDLE, ACTIVE, DRAIN, DONE, TIMEOUT.
- IDLE:
  - Counting still runs, so objections raised before start are held.
  - start -> ACTIVE; clears elapsed, done, timed_out and both error flags.
- ACTIVE:
  - elapsed increments each cycle.
  - Registered objection_count == 0 -> DRAIN; drain counter loaded with DRAIN_CYCLES-1.
- DRAIN:
  - elapsed keeps incrementing.
  - objection_count != 0 -> ACTIVE (drain aborted).
  - Otherwise drain counter == 0 -> DONE; else decrement.
- Watchdog: in ACTIVE or DRAIN, if timeout_limit != 0 and elapsed+1 == timeout_limit, go to TIMEOUT and set timed_out. This has priority over every other transition in the same cycle.
- DONE and TIMEOUT:
  - done/timed_out held high; elapsed frozen.
  - start re-arms: -> ACTIVE with the same clears as in IDLE.
- start while ACTIVE/DRAIN: restart, i.e. clear elapsed and flags, go to ACTIVE.
- Latency:
  - done rises exactly DRAIN_CYCLES+1 edges after the first edge at which objection_count reads 0 in ACTIVE, given no intervening raise.
  - A start with count already 0 gives done DRAIN_CYCLES+2 edges after the start edge.
  - timed_out rises timeout_limit edges after the start edge.
- busy = (state==ACTIVE || state==DRAIN), registered with the state.
- elapsed saturates at all-ones; it does not wrap.
- Reset mid-operation: immediate return to IDLE with count 0; objections in flight are lost.

Decomposition:
- Shared package svt_hw_pkg holds:
  - typedef enum logic [2:0] svt_obj_state_e {IDLE, ACTIVE, DRAIN, DONE, TIMEOUT};
  - the signed delta-width helper function.
- One sub-module, svt_popcount: parameterized combinational count of ones, width NUM_SRC -> $clog2(NUM_SRC+1).
  - Instantiated twice, once for raise and once for drop.

Test Plan:
- Basic drain: DRAIN_CYCLES=16; start with count 0 -> DRAIN next edge; done=1 exactly 18 edges after start; elapsed frozen at 17.
- Raise/drop: start, raise=4'b0011, later drop=4'b0001, then drop=4'b0010 -> count reads 2, 1, 0; done 17 edges after count reads 0.
- Drain abort: count reaches 0, raise on lane 2 at drain cycle 5 -> back to ACTIVE, count 1; done only after the later drop + 17 edges.
- Watchdog: timeout_limit=100, raise once, never drop -> timed_out=1 at edge 100 after start; done stays 0; busy=0.
- Timeout vs drain tie: configure the last drain cycle to coincide with elapsed+1==limit -> state TIMEOUT; done=0.
- Errors: count 0, drop=4'b1111 -> count 0, err_underflow=1; CNT_W=2, count 3, raise=4'b0001 -> count 3, err_overflow=1; next start clears both.

Source files
------------

// File: rtl/svt_hw_pkg.sv
// ---------------------------------------------------------------------------
// svt_hw_pkg
//
// Shared definitions for the hardware-side end-of-test objection logic.
//
// Contents:
//   svt_obj_state_e  - controller state encoding
//   svt_delta_width  - width of the signed scratch value used when the
//                      objection count and the per-cycle net change are
//                      combined, before clamping back into the counter
// ---------------------------------------------------------------------------
package svt_hw_pkg;

  // Controller states. IDLE is only left on start; DONE and TIMEOUT are
  // terminal until the next start re-arms the controller.
  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE,
    TIMEOUT
  } svt_obj_state_e;

  // The sum count + popcount(raise) - popcount(drop) needs enough headroom
  // to hold count_max + num_src without wrapping, plus a sign bit so that a
  // drop below zero is visible as a negative value. One extra bit over the
  // strict minimum keeps the compare logic free of corner cases when
  // num_src is a power of two.
  function automatic int svt_delta_width(input int cnt_w, input int num_src);
    return cnt_w + $clog2(num_src) + 2;
  endfunction

endpackage

// File: rtl/svt_popcount.sv
// ---------------------------------------------------------------------------
// svt_popcount
//
// Purely combinational population count: number of set bits in vec.
//
// Parameters:
//   WIDTH  - number of input bits
//
// Ports:
//   vec    in   WIDTH              bits to count
//   ones   out  $clog2(WIDTH+1)    number of bits set in vec
// ---------------------------------------------------------------------------
module svt_popcount #(
  parameter int WIDTH = 4,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [OUT_W-1:0] ones
);

  // Simple ripple sum over the lanes. The lane count is small (one bit per
  // objection source), so a linear adder chain is the clearest form and
  // synthesis flattens it into a compact adder tree anyway.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OUT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/svt_objection_ctrl.sv
// ---------------------------------------------------------------------------
// svt_objection_ctrl
//
// End-of-test controller living on the DUT/harness side. Hardware agents
// pulse raise/drop on their own lane; this block keeps one saturating
// objection count, waits for the count to stay at zero for a drain period,
// and reports done. A watchdog reports timed_out if the run takes too long.
// The test-runner waits on done/timed_out before ending the simulation.
//
// Parameters:
//   NUM_SRC       - number of objection source lanes
//   CNT_W         - objection counter width (saturates at 2^CNT_W-1)
//   TIMEOUT_W     - width of the watchdog limit and elapsed counter
//   DRAIN_CYCLES  - cycles the count must stay zero before done (>= 1)
//
// Ports:
//   clock            in   1          rising-edge clock
//   reset_n          in   1          asynchronous active-low reset
//   start            in   1          pulse: arm / re-arm the controller
//   raise            in   NUM_SRC    per-lane pulse: add one objection
//   drop             in   NUM_SRC    per-lane pulse: remove one objection
//   timeout_limit    in   TIMEOUT_W  watchdog limit in cycles, 0 = off
//   objection_count  out  CNT_W      current objection count
//   elapsed          out  TIMEOUT_W  cycles spent in ACTIVE/DRAIN this run
//   busy             out  1          controller in ACTIVE or DRAIN
//   done             out  1          sticky: drain completed
//   timed_out        out  1          sticky: watchdog expired
//   err_underflow    out  1          sticky: drop below zero was clamped
//   err_overflow     out  1          sticky: raise above max was clamped
// ---------------------------------------------------------------------------
module svt_objection_ctrl
  import svt_hw_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int CNT_W        = 8,
  parameter int TIMEOUT_W    = 32,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_SRC-1:0]   raise,
  input  logic [NUM_SRC-1:0]   drop,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [CNT_W-1:0]     objection_count,
  output logic [TIMEOUT_W-1:0] elapsed,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  localparam int DELTA_W = svt_delta_width(CNT_W, NUM_SRC);
  localparam int POP_W   = $clog2(NUM_SRC + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [DRAIN_W-1:0]        DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic signed [DELTA_W-1:0] COUNT_MAX  = DELTA_W'({CNT_W{1'b1}});

  svt_obj_state_e          state;
  logic [DRAIN_W-1:0]      drain_cnt;

  logic [POP_W-1:0]        raise_ones;
  logic [POP_W-1:0]        drop_ones;
  logic signed [DELTA_W-1:0] count_sum;
  logic                    underflow_now;
  logic                    overflow_now;
  logic [CNT_W-1:0]        next_count;

  logic [TIMEOUT_W-1:0]    elapsed_inc;
  logic [TIMEOUT_W:0]      elapsed_plus_one;
  logic                    watchdog_hit;

  // One popcount per direction. A lane that raises and drops in the same
  // cycle adds one to each side, so it nets out to zero on its own.
  svt_popcount #(
    .WIDTH (NUM_SRC)
  ) u_raise_pop (
    .vec  (raise),
    .ones (raise_ones)
  );

  svt_popcount #(
    .WIDTH (NUM_SRC)
  ) u_drop_pop (
    .vec  (drop),
    .ones (drop_ones)
  );

  // Combine the current count with this cycle's net change in a wider
  // signed value, then clamp into [0, max]. A negative sum means more drops
  // than outstanding objections; a sum above max means the counter would
  // wrap. Either case is clamped and flagged instead of corrupting the
  // count.
  always_comb begin
    count_sum     = $signed(DELTA_W'(objection_count))
                  + $signed(DELTA_W'(raise_ones))
                  - $signed(DELTA_W'(drop_ones));
    underflow_now = count_sum[DELTA_W-1];
    overflow_now  = !underflow_now && (count_sum > COUNT_MAX);
    next_count    = count_sum[CNT_W-1:0];
    if (underflow_now) begin
      next_count = '0;
    end else if (overflow_now) begin
      next_count = '1;
    end
  end

  // Watchdog bookkeeping. elapsed sticks at all-ones rather than wrapping,
  // and the limit compare is done one bit wider so a saturated elapsed can
  // never alias onto a small limit value.
  always_comb begin
    elapsed_inc      = (&elapsed) ? elapsed : elapsed + TIMEOUT_W'(1);
    elapsed_plus_one = {1'b0, elapsed} + (TIMEOUT_W + 1)'(1);
    watchdog_hit     = (timeout_limit != '0)
                    && (elapsed_plus_one == {1'b0, timeout_limit});
  end

  // The objection count runs in every state so that objections raised
  // before start are already held when the run begins. The error flags are
  // sticky for the run; start wipes the history of the previous run, but a
  // clamp in the start cycle itself still belongs to the new run and is
  // kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      objection_count <= '0;
      err_underflow   <= 1'b0;
      err_overflow    <= 1'b0;
    end else begin
      objection_count <= next_count;
      if (start) begin
        err_underflow <= underflow_now;
        err_overflow  <= overflow_now;
      end else begin
        err_underflow <= err_underflow | underflow_now;
        err_overflow  <= err_overflow | overflow_now;
      end
    end
  end

  // Main controller FSM with all its outputs registered alongside the
  // state.
  //
  // ACTIVE waits for the registered count to read zero, then DRAIN counts
  // down DRAIN_CYCLES-1 .. 0 while the count stays at zero; any objection
  // during the drain sends the controller back to ACTIVE. done is set on
  // the first cycle spent in DONE, which puts it DRAIN_CYCLES+1 edges after
  // the edge where ACTIVE first sees a zero count.
  //
  // While running, the watchdog wins over everything else in that cycle,
  // including a start and the final drain step, so a run that hits its
  // limit is always reported as timed out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      elapsed   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state     <= ACTIVE;
            busy      <= 1'b1;
            done      <= 1'b0;
            timed_out <= 1'b0;
            elapsed   <= '0;
          end else if (state == DONE) begin
            done <= 1'b1;
          end
        end

        ACTIVE, DRAIN: begin
          if (watchdog_hit) begin
            state     <= TIMEOUT;
            busy      <= 1'b0;
            timed_out <= 1'b1;
            elapsed   <= elapsed_inc;
          end else if (start) begin
            state     <= ACTIVE;
            busy      <= 1'b1;
            done      <= 1'b0;
            timed_out <= 1'b0;
            elapsed   <= '0;
          end else begin
            elapsed <= elapsed_inc;
            if (state == ACTIVE) begin
              if (objection_count == '0) begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LOAD;
              end
            end else if (objection_count != '0) begin
              state <= ACTIVE;
            end else if (drain_cnt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svt_objection_ctrl.sv
// ---------------------------------------------------------------------------
// tb_svt_objection_ctrl
//
// Directed bench for svt_objection_ctrl. A table of single-cycle vectors
// exercises the count arithmetic and error flags, then hand-written
// sequences cover drain latency, drain abort, watchdog, the watchdog/drain
// tie, asynchronous reset and counter overflow on a narrow instance.
// ---------------------------------------------------------------------------
module tb_svt_objection_ctrl;

  localparam int NUM_SRC      = 4;
  localparam int CNT_W        = 8;
  localparam int TIMEOUT_W    = 32;
  localparam int DRAIN_CYCLES = 16;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [NUM_SRC-1:0]   raise;
  logic [NUM_SRC-1:0]   drop;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic [CNT_W-1:0]     objection_count;
  logic [TIMEOUT_W-1:0] elapsed;
  logic                 busy;
  logic                 done;
  logic                 timed_out;
  logic                 err_underflow;
  logic                 err_overflow;

  logic                 s_start;
  logic [NUM_SRC-1:0]   s_raise;
  logic [NUM_SRC-1:0]   s_drop;
  logic [TIMEOUT_W-1:0] s_timeout_limit;
  logic [1:0]           s_count;
  logic [TIMEOUT_W-1:0] s_elapsed;
  logic                 s_busy;
  logic                 s_done;
  logic                 s_timed_out;
  logic                 s_err_underflow;
  logic                 s_err_overflow;

  int checks   = 0;
  int failures = 0;
  int edges;

  typedef struct {
    logic [NUM_SRC-1:0] raise;
    logic [NUM_SRC-1:0] drop;
    logic               start;
    int                 exp_count;
    logic               exp_uf;
    logic               exp_of;
    logic               exp_busy;
  } vec_t;

  localparam int NUM_VEC = 11;
  vec_t vectors [NUM_VEC];

  svt_objection_ctrl #(
    .NUM_SRC      (NUM_SRC),
    .CNT_W        (CNT_W),
    .TIMEOUT_W    (TIMEOUT_W),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .raise           (raise),
    .drop            (drop),
    .timeout_limit   (timeout_limit),
    .objection_count (objection_count),
    .elapsed         (elapsed),
    .busy            (busy),
    .done            (done),
    .timed_out       (timed_out),
    .err_underflow   (err_underflow),
    .err_overflow    (err_overflow)
  );

  // Narrow counter instance so saturation at the top is reachable quickly.
  svt_objection_ctrl #(
    .NUM_SRC      (NUM_SRC),
    .CNT_W        (2),
    .TIMEOUT_W    (TIMEOUT_W),
    .DRAIN_CYCLES (2)
  ) dut_small (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (s_start),
    .raise           (s_raise),
    .drop            (s_drop),
    .timeout_limit   (s_timeout_limit),
    .objection_count (s_count),
    .elapsed         (s_elapsed),
    .busy            (s_busy),
    .done            (s_done),
    .timed_out       (s_timed_out),
    .err_underflow   (s_err_underflow),
    .err_overflow    (s_err_overflow)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // One comparison: counts it, and reports a FAIL line on a mismatch.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the main instance from the falling edge,
  // returns just after the next rising edge, and clears the pulses.
  task automatic applyStimulus(input logic [NUM_SRC-1:0] r, input logic [NUM_SRC-1:0] d,
                               input logic s);
    @(negedge clock);
    raise = r;
    drop  = d;
    start = s;
    @(posedge clock);
    #1;
    raise = '0;
    drop  = '0;
    start = 1'b0;
  endtask

  // Same as applyStimulus, for the narrow instance.
  task automatic applySmall(input logic [NUM_SRC-1:0] r, input logic [NUM_SRC-1:0] d,
                            input logic s);
    @(negedge clock);
    s_raise = r;
    s_drop  = d;
    s_start = s;
    @(posedge clock);
    #1;
    s_raise = '0;
    s_drop  = '0;
    s_start = 1'b0;
  endtask

  task automatic idleEdges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Counts rising edges until done (sel 0) or timed_out (sel 1) reads high.
  // Returns -1 if the flag never rises within the limit.
  task automatic waitFlag(input int sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clock);
      #1;
      if ((sel == 0 && done) || (sel == 1 && timed_out)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    // count arithmetic and underflow in IDLE, finishing with a start
    vectors[0]  = '{4'b0011, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vectors[1]  = '{4'b0000, 4'b0001, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vectors[2]  = '{4'b1111, 4'b0000, 1'b0, 5, 1'b0, 1'b0, 1'b0};
    vectors[3]  = '{4'b0101, 4'b0101, 1'b0, 5, 1'b0, 1'b0, 1'b0};
    vectors[4]  = '{4'b1100, 4'b0011, 1'b0, 5, 1'b0, 1'b0, 1'b0};
    vectors[5]  = '{4'b0000, 4'b1111, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vectors[6]  = '{4'b0000, 4'b1111, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vectors[7]  = '{4'b0001, 4'b0000, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vectors[8]  = '{4'b0110, 4'b0110, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vectors[9]  = '{4'b0000, 4'b0001, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vectors[10] = '{4'b0000, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b1};

    reset_n         = 1'b0;
    start           = 1'b0;
    raise           = '0;
    drop            = '0;
    timeout_limit   = '0;
    s_start         = 1'b0;
    s_raise         = '0;
    s_drop          = '0;
    s_timeout_limit = '0;

    // reset state, sampled while reset is still held
    #12;
    checkOutput("reset_count", objection_count, 0);
    checkOutput("reset_elapsed", elapsed, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_timed_out", timed_out, 0);
    checkOutput("reset_uf", err_underflow, 0);
    checkOutput("reset_of", err_overflow, 0);
    checkOutput("reset_small_count", s_count, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // table-driven count/error vectors
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vectors[i].raise, vectors[i].drop, vectors[i].start);
      checkOutput($sformatf("vec%0d_count", i), objection_count, vectors[i].exp_count);
      checkOutput($sformatf("vec%0d_uf", i), err_underflow, vectors[i].exp_uf);
      checkOutput($sformatf("vec%0d_of", i), err_overflow, vectors[i].exp_of);
      checkOutput($sformatf("vec%0d_busy", i), busy, vectors[i].exp_busy);
    end

    // asynchronous reset in the middle of a run
    applyStimulus(4'b0011, 4'b0000, 1'b0);
    checkOutput("prereset_count", objection_count, 2);
    checkOutput("prereset_busy", busy, 1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_count", objection_count, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_elapsed", elapsed, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // basic drain: start with zero objections
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("drain_busy_after_start", busy, 1);
    waitFlag(0, 40, edges);
    checkOutput("drain_done_edges", edges, DRAIN_CYCLES + 2);
    checkOutput("drain_elapsed", elapsed, 17);
    checkOutput("drain_busy_end", busy, 0);
    checkOutput("drain_timed_out", timed_out, 0);
    idleEdges(3);
    checkOutput("drain_done_sticky", done, 1);
    checkOutput("drain_elapsed_frozen", elapsed, 17);

    // raise two lanes with start, then drop them one at a time
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    checkOutput("rd_count_2", objection_count, 2);
    checkOutput("rd_done_cleared", done, 0);
    checkOutput("rd_busy", busy, 1);
    idleEdges(2);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    checkOutput("rd_count_1", objection_count, 1);
    idleEdges(2);
    applyStimulus(4'b0000, 4'b0010, 1'b0);
    checkOutput("rd_count_0", objection_count, 0);
    waitFlag(0, 40, edges);
    checkOutput("rd_done_edges", edges, DRAIN_CYCLES + 2);
    checkOutput("rd_elapsed", elapsed, 23);

    // drain aborted by a raise on lane 2 partway through the drain
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("abort_count_1", objection_count, 1);
    idleEdges(2);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    idleEdges(5);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkOutput("abort_count_raised", objection_count, 1);
    idleEdges(15);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_busy", busy, 1);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    waitFlag(0, 40, edges);
    checkOutput("abort_done_edges", edges, DRAIN_CYCLES + 2);

    // watchdog with an objection that is never dropped
    timeout_limit = 100;
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    waitFlag(1, 150, edges);
    checkOutput("wd_edges", edges, 100);
    checkOutput("wd_done", done, 0);
    checkOutput("wd_busy", busy, 0);
    checkOutput("wd_elapsed", elapsed, 100);
    checkOutput("wd_count", objection_count, 1);
    idleEdges(3);
    checkOutput("wd_sticky", timed_out, 1);
    checkOutput("wd_elapsed_frozen", elapsed, 100);

    // watchdog landing on the final drain step wins over done
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    checkOutput("tie_count_0", objection_count, 0);
    timeout_limit = 17;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("tie_timed_out_cleared", timed_out, 0);
    waitFlag(1, 40, edges);
    checkOutput("tie_edges", edges, 17);
    idleEdges(5);
    checkOutput("tie_done", done, 0);
    checkOutput("tie_elapsed", elapsed, 17);
    timeout_limit = 0;

    // saturation on the 2-bit instance, then start clears both errors
    applySmall(4'b0011, 4'b0000, 1'b0);
    checkOutput("small_count_2", s_count, 2);
    applySmall(4'b0001, 4'b0000, 1'b0);
    checkOutput("small_count_3", s_count, 3);
    checkOutput("small_of_clear", s_err_overflow, 0);
    applySmall(4'b0001, 4'b0000, 1'b0);
    checkOutput("small_count_sat", s_count, 3);
    checkOutput("small_of_set", s_err_overflow, 1);
    applySmall(4'b0000, 4'b1111, 1'b0);
    checkOutput("small_count_floor", s_count, 0);
    checkOutput("small_uf_set", s_err_underflow, 1);
    checkOutput("small_of_sticky", s_err_overflow, 1);
    applySmall(4'b0000, 4'b0000, 1'b1);
    checkOutput("small_uf_cleared", s_err_underflow, 0);
    checkOutput("small_of_cleared", s_err_overflow, 0);
    checkOutput("small_busy", s_busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
